// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF, DM and memory-side signals around the arbiter.
// slave is the arbiter's view; master is the pipeline/memory environment's view.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_stall;

  logic        dm_req;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_rd_wr;
  logic [1:0]  dm_access_sz;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        dm_stall;

  logic        mem_enable;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [1:0]  mem_access_size;
  logic        mem_rd_wr;
  logic        mem_busy;
  logic [31:0] mem_data_out;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata, if_stall,
    input  dm_req, dm_addr, dm_wdata, dm_rd_wr, dm_access_sz,
    output dm_gnt, dm_rvalid, dm_rdata, dm_stall,
    output mem_enable, mem_addr, mem_data_in, mem_access_size, mem_rd_wr,
    input  mem_busy, mem_data_out
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata, if_stall,
    output dm_req, dm_addr, dm_wdata, dm_rd_wr, dm_access_sz,
    input  dm_gnt, dm_rvalid, dm_rdata, dm_stall,
    input  mem_enable, mem_addr, mem_data_in, mem_access_size, mem_rd_wr,
    output mem_busy, mem_data_out
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// IF/DM arbiter for one single-ported memory: same-cycle grant, read data routed back after MEM_LATENCY.
// No grant while mem_busy; a losing or blocked requester sees its stall flag and holds its request.
module mem_port_arbiter #(
  parameter int          MEM_LATENCY  = 1,
  parameter int          STARVE_MAX   = 4,
  parameter logic [1:0]  IF_ACCESS_SZ = 2'b01
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  arb
);

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  logic [2:0]             r_starve_cnt;
  logic [MEM_LATENCY-1:0] r_tag_vld;
  logic [MEM_LATENCY-1:0] r_tag_dm;

  logic w_issue;
  logic w_if_win;
  logic w_if_gnt;
  logic w_dm_gnt;
  logic w_rd_push;

  always_comb begin
    w_issue   = reset & ~arb.mem_busy & (arb.if_req | arb.dm_req);
    w_if_win  = arb.if_req & (~arb.dm_req | (r_starve_cnt == STARVE_LIM));
    w_if_gnt  = w_issue & w_if_win;
    w_dm_gnt  = w_issue & ~w_if_win;
    w_rd_push = w_if_gnt | (w_dm_gnt & arb.dm_rd_wr);
  end

  // Reset gates every output so the pipeline sees an idle port immediately.
  always_comb begin
    arb.if_gnt          = w_if_gnt;
    arb.dm_gnt          = w_dm_gnt;
    arb.if_stall        = reset & arb.if_req & ~w_if_gnt;
    arb.dm_stall        = reset & arb.dm_req & ~w_dm_gnt;
    arb.mem_enable      = w_issue;
    arb.mem_addr        = w_if_gnt ? arb.if_addr : (w_dm_gnt ? arb.dm_addr : 32'h0);
    arb.mem_data_in     = w_dm_gnt ? arb.dm_wdata : 32'h0;
    arb.mem_access_size = w_if_gnt ? IF_ACCESS_SZ : (w_dm_gnt ? arb.dm_access_sz : 2'b00);
    arb.mem_rd_wr       = ~w_dm_gnt | arb.dm_rd_wr;
    arb.if_rvalid       = reset & r_tag_vld[MEM_LATENCY-1] & ~r_tag_dm[MEM_LATENCY-1];
    arb.dm_rvalid       = reset & r_tag_vld[MEM_LATENCY-1] &  r_tag_dm[MEM_LATENCY-1];
    arb.if_rdata        = reset ? arb.mem_data_out : 32'h0;
    arb.dm_rdata        = reset ? arb.mem_data_out : 32'h0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve_cnt <= 3'd0;
    end else if (!arb.mem_busy) begin
      if (!arb.if_req || w_if_gnt) begin
        r_starve_cnt <= 3'd0;
      end else if (w_dm_gnt && (r_starve_cnt != STARVE_LIM)) begin
        r_starve_cnt <= r_starve_cnt + 3'd1;
      end
    end
  end

  // Tag pipeline mirrors the memory's fixed read latency; the tail selects the owner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tag_vld <= '0;
      r_tag_dm  <= '0;
    end else begin
      for (int i = MEM_LATENCY - 1; i > 0; i--) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_dm[i]  <= r_tag_dm[i-1];
      end
      r_tag_vld[0] <= w_rd_push;
      r_tag_dm[0]  <= w_dm_gnt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench: two arbiters (MEM_LATENCY 1 and 3) on shared stimulus; vector table plus hand sequences,
// read responses checked against a per-instance scoreboard queue.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if b1 ();
  mem_port_arbiter_if b3 ();

  assign b3.if_req       = b1.if_req;
  assign b3.if_addr      = b1.if_addr;
  assign b3.dm_req       = b1.dm_req;
  assign b3.dm_addr      = b1.dm_addr;
  assign b3.dm_wdata     = b1.dm_wdata;
  assign b3.dm_rd_wr     = b1.dm_rd_wr;
  assign b3.dm_access_sz = b1.dm_access_sz;
  assign b3.mem_busy     = b1.mem_busy;
  assign b3.mem_data_out = b1.mem_data_out;

  mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_MAX(4), .IF_ACCESS_SZ(2'b01)) dut1 (
    .clk(clk), .reset(reset), .arb(b1));
  mem_port_arbiter #(.MEM_LATENCY(3), .STARVE_MAX(4), .IF_ACCESS_SZ(2'b01)) dut3 (
    .clk(clk), .reset(reset), .arb(b3));

  typedef struct packed {
    logic        if_gnt;
    logic        dm_gnt;
    logic        if_stall;
    logic        dm_stall;
    logic        en;
    logic [31:0] addr;
    logic [31:0] din;
    logic [1:0]  sz;
    logic        rw;
  } out_t;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_rd_wr;
    logic [1:0]  dm_sz;
    logic        busy;
    out_t        exp;
  } vec_t;

  typedef struct {
    logic own_dm;
    int   due;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  vec_t tbl[10];

  function automatic out_t eo(input logic ig, input logic dg, input logic is, input logic ds,
                              input logic en, input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] sz, input logic rw);
    out_t o;
    o = {ig, dg, is, ds, en, a, d, sz, rw};
    return o;
  endfunction

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                              input logic [31:0] da, input logic [31:0] wd, input logic rw,
                              input logic [1:0] sz, input logic bz, input out_t e);
    vec_t v;
    v.if_req = ir; v.if_addr = ia; v.dm_req = dr; v.dm_addr = da;
    v.dm_wdata = wd; v.dm_rd_wr = rw; v.dm_sz = sz; v.busy = bz; v.exp = e;
    return v;
  endfunction

  function automatic out_t outs(input int k);
    out_t o;
    if (k == 0)
      o = {b1.if_gnt, b1.dm_gnt, b1.if_stall, b1.dm_stall, b1.mem_enable,
           b1.mem_addr, b1.mem_data_in, b1.mem_access_size, b1.mem_rd_wr};
    else
      o = {b3.if_gnt, b3.dm_gnt, b3.if_stall, b3.dm_stall, b3.mem_enable,
           b3.mem_addr, b3.mem_data_in, b3.mem_access_size, b3.mem_rd_wr};
    return o;
  endfunction

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [31:0] da, input logic [31:0] wd, input logic rw,
                       input logic [1:0] sz, input logic bz);
    b1.if_req = ir; b1.if_addr = ia; b1.dm_req = dr; b1.dm_addr = da;
    b1.dm_wdata = wd; b1.dm_rd_wr = rw; b1.dm_access_sz = sz; b1.mem_busy = bz;
    b1.mem_data_out = $urandom;
  endtask

  // Record the read response a grant in the current cycle must produce.
  task automatic exp_issue(input logic is_if, input logic is_dm_rd);
    exp_t e;
    if (is_if || is_dm_rd) begin
      e.own_dm = ~is_if;
      e.due = cyc + 1;
      q1.push_back(e);
      e.due = cyc + 3;
      q3.push_back(e);
    end
  endtask

  task automatic mon(input int k, input logic iv, input logic dv,
                     input logic [31:0] ir, input logic [31:0] dr);
    exp_t e;
    int   n;
    n = (k == 0) ? q1.size() : q3.size();
    if (n > 0) e = (k == 0) ? q1[0] : q3[0];
    if (iv || dv) begin
      n_cmp++;
      if (n == 0) begin
        n_bad++;
        $display("FAIL rvalid_unexpected L%0d cyc %0d: got if=%b dm=%b expected none", k*2+1, cyc, iv, dv);
      end else begin
        if (k == 0) void'(q1.pop_front()); else void'(q3.pop_front());
        if (e.due != cyc || (iv && dv) || dv != e.own_dm || (dv ? dr : ir) != b1.mem_data_out) begin
          n_bad++;
          $display("FAIL rsp L%0d cyc %0d: got if=%b dm=%b data=%h expected dm=%b due=%0d data=%h",
                   k*2+1, cyc, iv, dv, dv ? dr : ir, e.own_dm, e.due, b1.mem_data_out);
        end
      end
    end else if (n > 0 && e.due <= cyc) begin
      n_cmp++;
      n_bad++;
      if (k == 0) void'(q1.pop_front()); else void'(q3.pop_front());
      $display("FAIL rsp_missing L%0d cyc %0d: got no rvalid expected dm=%b due=%0d", k*2+1, cyc, e.own_dm, e.due);
    end
  endtask

  always @(negedge clk) begin
    mon(0, b1.if_rvalid, b1.dm_rvalid, b1.if_rdata, b1.dm_rdata);
    mon(1, b3.if_rvalid, b3.dm_rvalid, b3.if_rdata, b3.dm_rdata);
  end

  localparam logic [1:0] GN = 2'b00, GI = 2'b10, GD = 2'b01;

  initial begin
    logic [1:0] pat_a [6];
    logic [1:0] pat_b [9];
    pat_a = '{GD, GD, GD, GD, GI, GD};
    pat_b = '{GD, GD, GD, GN, GN, GN, GD, GI, GD};

    tbl[0] = mk(0, 32'h0,   0, 32'h0,    32'h0,        1, 2'b00, 0, eo(0,0,0,0,0, 32'h0,    32'h0,        2'b00, 1));
    tbl[1] = mk(1, 32'h100, 0, 32'h0,    32'h0,        1, 2'b00, 0, eo(1,0,0,0,1, 32'h100,  32'h0,        2'b01, 1));
    tbl[2] = mk(1, 32'h100, 1, 32'h2000, 32'h11112222, 1, 2'b10, 0, eo(0,1,1,0,1, 32'h2000, 32'h11112222, 2'b10, 1));
    tbl[3] = mk(1, 32'h104, 0, 32'h0,    32'h0,        1, 2'b00, 0, eo(1,0,0,0,1, 32'h104,  32'h0,        2'b01, 1));
    tbl[4] = mk(0, 32'h0,   1, 32'h3000, 32'hDEADBEEF, 0, 2'b00, 0, eo(0,1,0,0,1, 32'h3000, 32'hDEADBEEF, 2'b00, 0));
    tbl[5] = mk(0, 32'h0,   1, 32'h40,   32'h0,        1, 2'b11, 0, eo(0,1,0,0,1, 32'h40,   32'h0,        2'b11, 1));
    tbl[6] = mk(1, 32'h108, 1, 32'h44,   32'h0,        1, 2'b10, 1, eo(0,0,1,1,0, 32'h0,    32'h0,        2'b00, 1));
    tbl[7] = mk(0, 32'h0,   1, 32'h44,   32'h77,       0, 2'b10, 1, eo(0,0,0,1,0, 32'h0,    32'h0,        2'b00, 1));
    tbl[8] = mk(1, 32'h10C, 1, 32'h48,   32'hA5A5,     0, 2'b01, 0, eo(0,1,1,0,1, 32'h48,   32'hA5A5,     2'b01, 0));
    tbl[9] = mk(0, 32'h0,   0, 32'h0,    32'h0,        1, 2'b00, 0, eo(0,0,0,0,0, 32'h0,    32'h0,        2'b00, 1));

    // Reset with both requests pending: port must look idle.
    reset = 1'b0;
    drive(1, 32'h100, 1, 32'h2000, 32'h5, 1, 2'b10, 0);
    tick();
    #3;
    chk("reset_out_L1", outs(0), eo(0,0,0,0,0, 32'h0, 32'h0, 2'b00, 1));
    chk("reset_out_L3", outs(1), eo(0,0,0,0,0, 32'h0, 32'h0, 2'b00, 1));
    tick();
    drive(0, 32'h0, 0, 32'h0, 32'h0, 1, 2'b00, 0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].if_req, tbl[i].if_addr, tbl[i].dm_req, tbl[i].dm_addr,
            tbl[i].dm_wdata, tbl[i].dm_rd_wr, tbl[i].dm_sz, tbl[i].busy);
      exp_issue(tbl[i].exp.if_gnt, tbl[i].exp.dm_gnt & tbl[i].dm_rd_wr);
      #3;
      chk($sformatf("vec%0d_L1", i), outs(0), tbl[i].exp);
      chk($sformatf("vec%0d_L3", i), outs(1), tbl[i].exp);
      tick();
    end

    // Starvation: DM x4, then IF forced, then DM again.
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'h200, 1, 32'h300, 32'h0, 1, 2'b10, 0);
      exp_issue(pat_a[i][1], pat_a[i][0]);
      #3;
      chk($sformatf("starve%0d", i), {b1.if_gnt, b1.dm_gnt}, pat_a[i]);
      tick();
    end
    drive(0, 32'h0, 0, 32'h0, 32'h0, 1, 2'b00, 0);
    tick();

    // Busy window freezes the starvation count and blocks all grants.
    for (int i = 0; i < 9; i++) begin
      drive(1, 32'h204, 1, 32'h304, 32'h0, 1, 2'b01, (i >= 3 && i <= 5));
      exp_issue(pat_b[i][1], pat_b[i][0]);
      #3;
      chk($sformatf("busy%0d", i), {b1.if_gnt, b1.dm_gnt, b1.mem_enable},
          {pat_b[i], pat_b[i] != GN});
      tick();
    end
    drive(0, 32'h0, 0, 32'h0, 32'h0, 1, 2'b00, 0);
    for (int i = 0; i < 4; i++) tick();

    // Reset one cycle after an IF read: outputs drop at once, in-flight response is dropped.
    drive(1, 32'h500, 0, 32'h0, 32'h0, 1, 2'b00, 0);
    exp_issue(1, 0);
    #3;
    chk("pre_reset_gnt", b3.if_gnt, 1'b1);
    tick();
    reset = 1'b0;
    q1.delete();
    q3.delete();
    #1;
    chk("async_reset_L1", outs(0), eo(0,0,0,0,0, 32'h0, 32'h0, 2'b00, 1));
    chk("async_reset_L3", outs(1), eo(0,0,0,0,0, 32'h0, 32'h0, 2'b00, 1));
    tick();
    drive(0, 32'h0, 0, 32'h0, 32'h0, 1, 2'b00, 0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    drive(1, 32'h600, 0, 32'h0, 32'h0, 1, 2'b00, 0);
    exp_issue(1, 0);
    #3;
    chk("post_reset_gnt", outs(1), eo(1,0,0,0,1, 32'h600, 32'h0, 2'b01, 1));
    tick();
    drive(0, 32'h0, 0, 32'h0, 32'h0, 1, 2'b00, 0);
    for (int i = 0; i < 6; i++) tick();

    chk("drain_L1", q1.size(), 0);
    chk("drain_L3", q3.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
